// File: rtl/ksa_gen.sv
// ksa_gen: parametrised ARC4 key-scheduling engine driving a 256x8 S memory.
//
// Build option:
//   KSA_INIT_EN  defined   : an INIT pass writes S[n]=n before the KSA loop.
//                undefined : the caller preloads S[n]=n; the loop starts at once.
//
// Parameters:
//   KEY_BYTES   key length in bytes (1..32)
//   RD_LATENCY  S memory read latency in cycles (1..2)
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   en      start request, honoured only while rdy=1
//   rdy     1 = idle, ready to accept en
//   key     key, byte 0 in the most significant byte
//   addr    S memory address
//   rddata  S memory read data (valid RD_LATENCY cycles after addr)
//   wrdata  S memory write data
//   wren    S memory write enable, one cycle per write
module ksa_gen #(
    parameter int unsigned KEY_BYTES  = 3,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             addr,
    input  logic [7:0]             rddata,
    output logic [7:0]             wrdata,
    output logic                   wren
);

    localparam int unsigned KEY_W        = 8 * KEY_BYTES;
    localparam int unsigned KIDX_W       = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
    localparam bit          TWO_CYCLE_RD = (RD_LATENCY > 1);
    localparam logic [7:0]  LAST_IDX     = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE,
`ifdef KSA_INIT_EN
        S_INIT,
`endif
        S_RD_I,
        S_WAIT_I,
        S_CAP_I,
        S_RD_J,
        S_WAIT_J,
        S_CAP_J,
        S_WR_J,
        S_WR_I,
        S_DONE
    } state_t;

    state_t              state;
    logic [KEY_W-1:0]    key_q;
    logic [7:0]          i;
    logic [7:0]          j;
    logic [7:0]          si;
    logic [7:0]          sj;
    logic [KIDX_W-1:0]   kidx;

    logic [7:0]          kb_c;
    logic [7:0]          j_next_c;

    // Key byte (i mod KEY_BYTES), selected by the wrapping key index.
    always_comb begin
        kb_c = 8'h00;
        for (int unsigned k = 0; k < KEY_BYTES; k++) begin
            if (kidx == KIDX_W'(k)) begin
                kb_c = key_q[KEY_W-1-8*k -: 8];
            end
        end
    end

    // New j, 8-bit wrap; only meaningful in CAP_I where rddata holds S[i].
    always_comb begin
        j_next_c = j + rddata + kb_c;
    end

    // Control FSM with registered memory-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rdy    <= 1'b1;
            wren   <= 1'b0;
            addr   <= 8'h00;
            wrdata <= 8'h00;
            i      <= 8'h00;
            j      <= 8'h00;
            si     <= 8'h00;
            sj     <= 8'h00;
            kidx   <= '0;
            key_q  <= '0;
        end else begin
            // Writes are single-cycle; only the write states re-assert wren.
            wren <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en) begin
                        key_q <= key;
                        i     <= 8'h00;
                        j     <= 8'h00;
                        kidx  <= '0;
                        rdy   <= 1'b0;
                        addr  <= 8'h00;
`ifdef KSA_INIT_EN
                        wrdata <= 8'h00;
                        wren   <= 1'b1;
                        state  <= S_INIT;
`else
                        state  <= S_RD_I;
`endif
                    end
                end

`ifdef KSA_INIT_EN
                // i doubles as the fill counter; cycle n writes S[n]=n.
                S_INIT: begin
                    if (i == LAST_IDX) begin
                        i     <= 8'h00;
                        j     <= 8'h00;
                        addr  <= 8'h00;
                        state <= S_RD_I;
                    end else begin
                        i      <= i + 8'd1;
                        addr   <= i + 8'd1;
                        wrdata <= i + 8'd1;
                        wren   <= 1'b1;
                    end
                end
`endif

                S_RD_I: begin
                    state <= TWO_CYCLE_RD ? S_WAIT_I : S_CAP_I;
                end

                S_WAIT_I: begin
                    state <= S_CAP_I;
                end

                S_CAP_I: begin
                    si    <= rddata;
                    j     <= j_next_c;
                    addr  <= j_next_c;
                    kidx  <= (kidx == KIDX_LAST) ? '0 : kidx + KIDX_W'(1);
                    state <= S_RD_J;
                end

                S_RD_J: begin
                    state <= TWO_CYCLE_RD ? S_WAIT_J : S_CAP_J;
                end

                S_WAIT_J: begin
                    state <= S_CAP_J;
                end

                S_CAP_J: begin
                    sj     <= rddata;
                    addr   <= j;
                    wrdata <= si;
                    wren   <= 1'b1;
                    state  <= S_WR_J;
                end

                // When i==j both writes carry the same value, leaving S[i] intact.
                S_WR_J: begin
                    addr   <= i;
                    wrdata <= sj;
                    wren   <= 1'b1;
                    state  <= S_WR_I;
                end

                S_WR_I: begin
                    if (i == LAST_IDX) begin
                        state <= S_DONE;
                    end else begin
                        i     <= i + 8'd1;
                        addr  <= i + 8'd1;
                        state <= S_RD_I;
                    end
                end

                S_DONE: begin
                    rdy   <= 1'b1;
                    state <= S_IDLE;
                end

                default: begin
                    rdy   <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ksa_gen.sv
// Scoreboard bench for ksa_gen: two instances (3-byte key / latency 1 and
// 8-byte key / latency 2), each with its own S memory model. Expected S boxes
// come from a plain software ARC4 key schedule.
module tb_ksa_gen;

    typedef logic [255:0][7:0] sbox_t;
    typedef struct {
        int    busy;
        int    first_wren;
        sbox_t s;
    } exp_t;

`ifdef KSA_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        en0, rdy0, wren0;
    logic [23:0] key0;
    logic [7:0]  addr0, rddata0, wrdata0;
    logic        en1, rdy1, wren1;
    logic [63:0] key1;
    logic [7:0]  addr1, rddata1, wrdata1;

    ksa_gen #(.KEY_BYTES(3), .RD_LATENCY(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .rdy(rdy0), .key(key0),
        .addr(addr0), .rddata(rddata0), .wrdata(wrdata0), .wren(wren0)
    );

    ksa_gen #(.KEY_BYTES(8), .RD_LATENCY(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .rdy(rdy1), .key(key1),
        .addr(addr1), .rddata(rddata1), .wrdata(wrdata1), .wren(wren1)
    );

    // S memories: synchronous read, latency 1 and 2; pre* loads identity.
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic       pre0 = 1'b0;
    logic       pre1 = 1'b0;
    logic [7:0] pipe1;

    always @(posedge clk) begin
        if (pre0) for (int k = 0; k < 256; k++) mem0[k] <= 8'(k);
        else if (wren0) mem0[addr0] <= wrdata0;
        rddata0 <= mem0[addr0];
    end

    always @(posedge clk) begin
        if (pre1) for (int k = 0; k < 256; k++) mem1[k] <= 8'(k);
        else if (wren1) mem1[addr1] <= wrdata1;
        pipe1   <= mem1[addr1];
        rddata1 <= pipe1;
    end

    sbox_t mdl [2];
    exp_t  q0 [$];
    exp_t  q1 [$];

    function automatic sbox_t identity();
        sbox_t s;
        for (int k = 0; k < 256; k++) s[k] = 8'(k);
        return s;
    endfunction

    // Software ARC4 key schedule applied to a given starting S.
    function automatic sbox_t ksa_ref(sbox_t s_in, logic [255:0] k, int n);
        sbox_t s = s_in;
        int j = 0;
        logic [7:0] t;
        for (int i = 0; i < 256; i++) begin
            j = (j + int'(s[i]) + int'(k[8*(n-1-(i%n)) +: 8])) % 256;
            t    = s[i];
            s[i] = s[j];
            s[j] = t;
        end
        return s;
    endfunction

    function automatic logic get_rdy(int sel);
        return (sel != 0) ? rdy1 : rdy0;
    endfunction

    function automatic logic get_wren(int sel);
        return (sel != 0) ? wren1 : wren0;
    endfunction

    function automatic logic [7:0] get_mem(int sel, int k);
        return (sel != 0) ? mem1[k] : mem0[k];
    endfunction

    task automatic check(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Push the expected outcome of a run started now with key k.
    task automatic expect_run(int sel, logic [255:0] k);
        exp_t  e;
        int    nb  = (sel != 0) ? 8 : 3;
        int    lat = (sel != 0) ? 2 : 1;
        sbox_t st  = INIT_EN ? identity() : mdl[sel];
        e.s          = ksa_ref(st, k, nb);
        e.busy       = (INIT_EN ? 256 : 0) + 256 * (4 + 2 * lat) + 1;
        e.first_wren = INIT_EN ? 0 : (2 + 2 * lat);
        mdl[sel]     = e.s;
        if (sel != 0) q1.push_back(e);
        else          q0.push_back(e);
    endtask

    task automatic drive_en(int sel, logic v, logic [255:0] k);
        if (sel != 0) begin
            en1  = v;
            key1 = k[63:0];
        end else begin
            en0  = v;
            key0 = k[23:0];
        end
    endtask

    task automatic preload(int sel);
        @(negedge clk);
        if (sel != 0) pre1 = 1'b1;
        else          pre0 = 1'b1;
        @(negedge clk);
        pre0 = 1'b0;
        pre1 = 1'b0;
        mdl[sel] = identity();
    endtask

    task automatic start(int sel, logic [255:0] k, bit push);
        @(negedge clk);
        drive_en(sel, 1'b1, k);
        if (push) expect_run(sel, k);
        @(negedge clk);
        drive_en(sel, 1'b0, k);
    endtask

    task automatic wait_idle(int sel);
        bit seen = 1'b0;
        for (int n = 0; n < 6000 && !seen; n++) begin
            @(negedge clk);
            if (get_rdy(sel) === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL wait_idle dut%0d: rdy still %b after 6000 cycles", sel, get_rdy(sel));
        end
    endtask

    task automatic check_done(int sel, int busy, int fw);
        exp_t e;
        int   bad = -1;
        if ((sel != 0 ? q1.size() : q0.size()) == 0) begin
            compared++;
            mismatched++;
            $display("FAIL completion dut%0d: rdy rose with no run expected", sel);
            return;
        end
        e = (sel != 0) ? q1.pop_front() : q0.pop_front();
        check($sformatf("busy_cycles dut%0d", sel), busy, e.busy);
        check($sformatf("first_wren dut%0d", sel), fw, e.first_wren);
        check($sformatf("done_wren dut%0d", sel), int'(get_wren(sel)), 0);
        for (int k = 0; k < 256; k++)
            if (bad < 0 && get_mem(sel, k) !== e.s[k]) bad = k;
        compared++;
        if (bad >= 0) begin
            mismatched++;
            $display("FAIL sbox dut%0d: S[%0d]=%02h, expected %02h",
                     sel, bad, get_mem(sel, bad), e.s[bad]);
        end
    endtask

    // Monitor: counts busy cycles, locates first write, scores each completion.
    task automatic monitor(int sel);
        int busy = 0;
        int fw   = -1;
        int post = 0;
        bit prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 0;
                fw   = -1;
                post = 0;
                prev = 1'b1;
            end else begin
                if (get_rdy(sel) !== 1'b1) begin
                    if (get_wren(sel) === 1'b1 && fw < 0) fw = busy;
                    busy++;
                end else if (!prev) begin
                    check_done(sel, busy, fw);
                    busy = 0;
                    fw   = -1;
                    post = 3;
                end else if (post > 0) begin
                    check($sformatf("idle_wren dut%0d", sel), int'(get_wren(sel)), 0);
                    post--;
                end
                prev = (get_rdy(sel) === 1'b1);
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        logic [255:0] k1, k2;
        en0 = 1'b0; key0 = '0;
        en1 = 1'b0; key1 = '0;
        mdl[0] = identity();
        mdl[1] = identity();

        repeat (3) @(negedge clk);
        check("reset_rdy", int'(rdy0), 1);
        check("reset_wren", int'(wren0), 0);
        check("reset_addr", int'(addr0), 0);
        check("reset_wrdata", int'(wrdata0), 0);
        check("reset_rdy dut1", int'(rdy1), 1);
        @(negedge clk);
        rst_n = 1'b1;
        preload(1);

        // Fixed key, then all-ones key.
        preload(0); start(0, 256'h000155, 1'b1); wait_idle(0); repeat (4) @(negedge clk);
        preload(0); start(0, 256'hFFFFFF, 1'b1); wait_idle(0); repeat (4) @(negedge clk);

        // Mid-run en with a different key is ignored.
        k1 = 256'(24'($urandom()));
        preload(0); start(0, k1, 1'b1);
        repeat (698) @(negedge clk);
        drive_en(0, 1'b1, ~k1);
        @(negedge clk);
        drive_en(0, 1'b0, ~k1);
        wait_idle(0); repeat (4) @(negedge clk);

        // Reset in the middle of a run, then a clean restart.
        preload(0); start(0, 256'(24'($urandom())), 1'b0);
        repeat (898) @(negedge clk);
        check("pre_reset_rdy", int'(rdy0), 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_rdy", int'(rdy0), 1);
        check("async_reset_wren", int'(wren0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        preload(0); start(0, 256'h000155, 1'b1); wait_idle(0); repeat (4) @(negedge clk);

        // Back-to-back: en held through the cycle rdy rises.
        k1 = 256'(24'($urandom()));
        k2 = 256'(24'($urandom()));
        preload(0);
        @(negedge clk);
        drive_en(0, 1'b1, k1);
        expect_run(0, k1);
        @(negedge clk);
        drive_en(0, 1'b1, k2);
        wait_idle(0);
        expect_run(0, k2);
        @(negedge clk);
        drive_en(0, 1'b0, k2);
        wait_idle(0); repeat (4) @(negedge clk);

        repeat (2) begin
            preload(0); start(0, 256'(24'($urandom())), 1'b1); wait_idle(0); repeat (4) @(negedge clk);
        end

        // 8-byte key, read latency 2.
        preload(1); start(1, 256'h0123456789ABCDEF, 1'b1); wait_idle(1); repeat (4) @(negedge clk);
        repeat (2) begin
            preload(1);
            start(1, 256'({$urandom(), $urandom()}), 1'b1);
            wait_idle(1); repeat (4) @(negedge clk);
        end

        check("queue0_drained", q0.size(), 0);
        check("queue1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
